axilite_cmd_m: RTL and testbench

AXILITE_CMD_M -- requirements
Module: axilite_cmd_m

---
 rtl/axilite_cmd_m.sv | 228 ++++++++++++++++++++++
 tb/tb_axilite_cmd_m.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_cmd_m.sv
// axilite_cmd_m: single-outstanding AXI4-Lite master driven by a simple
// command/response interface.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn    clock; synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only while idle)
//   cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb
//                                 command fields, latched on acceptance
//   rsp_valid                    one-cycle completion pulse
//   rsp_rdata, rsp_resp          read data (0 for writes) and BRESP/RRESP
//   rsp_timeout                  set with rsp_valid when a wait state aborted
//   m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels
//
// Each wait state (WRITE, WRESP, RADDR, RDATA) is bounded by TIMEOUT_CYCLES;
// on expiry every VALID/READY drops and a SLVERR-coded response is returned.
module axilite_cmd_m #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,

  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,

  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,

  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,

  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,

  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,

  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  // Counter value in the last permitted cycle of a wait state.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        aw_done, w_done;
  logic [31:0] addr_q;
  logic        in_wait, timeout_hit, timeout_abort;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign b_hs  = m_axi_bvalid  & m_axi_bready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid  & m_axi_rready;

  assign in_wait     = (state == WRITE) || (state == WRESP) ||
                       (state == RADDR) || (state == RDATA);
  assign timeout_hit = in_wait && (wait_cnt == WAIT_LAST);

  // Gated by reset so no command appears acceptable while reset is held.
  assign cmd_ready    = (state == IDLE) && m_axi_aresetn;
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;

  // A completing handshake takes priority over a timeout in the same cycle.
  always_comb begin
    state_nxt     = state;
    timeout_abort = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = cmd_wr ? WRITE : RADDR;
      end
      WRITE: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt = WRESP;
        end else if (timeout_hit) begin
          state_nxt     = DONE;
          timeout_abort = 1'b1;
        end
      end
      WRESP: begin
        if (b_hs) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt     = DONE;
          timeout_abort = 1'b1;
        end
      end
      RADDR: begin
        if (ar_hs) begin
          state_nxt = RDATA;
        end else if (timeout_hit) begin
          state_nxt     = DONE;
          timeout_abort = 1'b1;
        end
      end
      RDATA: begin
        if (r_hs) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt     = DONE;
          timeout_abort = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      addr_q        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (in_wait) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q        <= cmd_addr;
            m_axi_wdata   <= cmd_wdata;
            m_axi_wstrb   <= cmd_wstrb;
            m_axi_awvalid <= cmd_wr;
            m_axi_wvalid  <= cmd_wr;
            m_axi_arvalid <= ~cmd_wr;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
          end
        end
        WRITE: begin
          // AW and W retire independently; WRESP waits for both.
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (state_nxt == WRESP) m_axi_bready <= 1'b1;
        end
        WRESP: begin
          if (b_hs) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
          end
        end
        RADDR: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (r_hs) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
            rsp_timeout  <= 1'b0;
          end
        end
        default: ;
      endcase

      if (timeout_abort) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axilite_cmd_m.sv
// tb_axilite_cmd_m: directed bench for axilite_cmd_m. Expected responses are
// queued when a command is issued; a monitor pops and compares on rsp_valid.
module tb_axilite_cmd_m;

  localparam int TO = 16;

  logic        m_axi_aclk = 1'b0;
  logic        m_axi_aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  always #5 m_axi_aclk = ~m_axi_aclk;

  axilite_cmd_m #(.TIMEOUT_CYCLES(TO)) dut (
    .m_axi_aclk    (m_axi_aclk),
    .m_axi_aresetn (m_axi_aresetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_wr        (cmd_wr),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;
  rsp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Slave model: each ready/valid is raised on the Nth cycle (0-based) that
  // the master's valid/ready has been seen high; 1000 means never.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  logic [31:0] s_rdata = '0;

  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_bresp = '0; m_axi_rresp = '0; m_axi_rdata = '0;
    forever begin
      @(negedge m_axi_aclk);
      if (m_axi_awvalid) begin m_axi_awready = (aw_cnt == aw_dly); aw_cnt++; end
      else begin m_axi_awready = 1'b0; aw_cnt = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_cnt == w_dly); w_cnt++; end
      else begin m_axi_wready = 1'b0; w_cnt = 0; end
      if (m_axi_bready) begin m_axi_bvalid = (b_cnt == b_dly); b_cnt++; end
      else begin m_axi_bvalid = 1'b0; b_cnt = 0; end
      if (m_axi_arvalid) begin m_axi_arready = (ar_cnt == ar_dly); ar_cnt++; end
      else begin m_axi_arready = 1'b0; ar_cnt = 0; end
      if (m_axi_rready) begin m_axi_rvalid = (r_cnt == r_dly); r_cnt++; end
      else begin m_axi_rvalid = 1'b0; r_cnt = 0; end
      m_axi_bresp = s_bresp;
      m_axi_rresp = s_rresp;
      m_axi_rdata = s_rdata;
    end
  end

  // Response monitor.
  always @(negedge m_axi_aclk) begin
    if (m_axi_aresetn && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual rdata=%h resp=%b to=%b required none",
                 rsp_rdata, rsp_resp, rsp_timeout);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
  end

  // Offer a command; returns at the negedge of the first post-accept cycle.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    @(negedge m_axi_aclk);
    cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 40) begin @(negedge m_axi_aclk); n++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge m_axi_aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int awd, input int wd,
                           input int bd, input logic [1:0] bresp);
    int m, beff, done_c;
    logic bto;
    rsp_t e;
    aw_dly = awd; w_dly = wd; b_dly = bd; s_bresp = bresp;
    m      = (awd > wd) ? awd : wd;
    bto    = (bd >= TO);
    beff   = bto ? TO - 1 : bd;
    done_c = m + 2 + beff;
    e.rdata = '0;
    e.resp  = bto ? 2'b10 : bresp;
    e.to    = bto;
    sb.push_back(e);
    issue(1'b1, addr, data, strb);
    for (int c = 0; c <= done_c + 1; c++) begin
      chk($sformatf("%s awvalid c%0d", tag, c), 32'(m_axi_awvalid), 32'(c <= awd));
      chk($sformatf("%s wvalid c%0d", tag, c), 32'(m_axi_wvalid), 32'(c <= wd));
      chk($sformatf("%s bready c%0d", tag, c), 32'(m_axi_bready),
          32'((c > m) && (c <= m + 1 + beff)));
      chk($sformatf("%s rsp_valid c%0d", tag, c), 32'(rsp_valid), 32'(c == done_c));
      chk($sformatf("%s cmd_ready c%0d", tag, c), 32'(cmd_ready), 32'(c == done_c + 1));
      if (c == awd) chk({tag, " awaddr"}, m_axi_awaddr, addr);
      if (c == wd) begin
        chk({tag, " wdata"}, m_axi_wdata, data);
        chk({tag, " wstrb"}, 32'(m_axi_wstrb), 32'(strb));
      end
      if (c <= done_c) @(negedge m_axi_aclk);
    end
  endtask

  task automatic run_read(input string tag, input logic [31:0] addr, input int ard,
                          input int rd, input logic [31:0] rdata, input logic [1:0] rresp);
    int done_c, arlast, rfirst, rlast;
    logic to;
    rsp_t e;
    ar_dly = ard; r_dly = rd; s_rdata = rdata; s_rresp = rresp;
    if (ard >= TO) begin
      to = 1'b1; arlast = TO - 1; rfirst = 1; rlast = 0; done_c = TO;
    end else if (rd >= TO) begin
      to = 1'b1; arlast = ard; rfirst = ard + 1; rlast = ard + TO; done_c = ard + TO + 1;
    end else begin
      to = 1'b0; arlast = ard; rfirst = ard + 1; rlast = ard + 1 + rd; done_c = ard + 2 + rd;
    end
    e.rdata = to ? 32'd0 : rdata;
    e.resp  = to ? 2'b10 : rresp;
    e.to    = to;
    sb.push_back(e);
    issue(1'b0, addr, 32'hFFFF_FFFF, 4'hF);
    for (int c = 0; c <= done_c + 1; c++) begin
      chk($sformatf("%s arvalid c%0d", tag, c), 32'(m_axi_arvalid), 32'(c <= arlast));
      chk($sformatf("%s rready c%0d", tag, c), 32'(m_axi_rready),
          32'((c >= rfirst) && (c <= rlast)));
      chk($sformatf("%s rsp_valid c%0d", tag, c), 32'(rsp_valid), 32'(c == done_c));
      chk($sformatf("%s cmd_ready c%0d", tag, c), 32'(cmd_ready), 32'(c == done_c + 1));
      if (c == 0) chk({tag, " araddr"}, m_axi_araddr, addr);
      if (c <= done_c) @(negedge m_axi_aclk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, " awvalid"}, 32'(m_axi_awvalid), 32'd0);
    chk({tag, " wvalid"}, 32'(m_axi_wvalid), 32'd0);
    chk({tag, " bready"}, 32'(m_axi_bready), 32'd0);
    chk({tag, " arvalid"}, 32'(m_axi_arvalid), 32'd0);
    chk({tag, " rready"}, 32'(m_axi_rready), 32'd0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, " awaddr"}, m_axi_awaddr, 32'd0);
    chk({tag, " araddr"}, m_axi_araddr, 32'd0);
    chk({tag, " wdata"}, m_axi_wdata, 32'd0);
    chk({tag, " wstrb"}, 32'(m_axi_wstrb), 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " rsp_resp"}, 32'(rsp_resp), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    m_axi_aresetn = 1'b0;
    repeat (3) @(posedge m_axi_aclk);
    #1;
    chk_all_zero("reset");
    @(negedge m_axi_aclk);
    m_axi_aresetn = 1'b1;
    @(negedge m_axi_aclk);
    chk("reset release cmd_ready", 32'(cmd_ready), 32'd1);

    run_write("wr_basic", 32'h0000_0087, 32'hC0DE_CAFE, 4'b1100, 2, 2, 0, 2'b00);
    run_read("rd_basic", 32'h0000_0087, 1, 2, 32'hC0DE_CAFE, 2'b00);
    run_write("wr_w_first", 32'h0000_1000, 32'h1122_3344, 4'hF, 4, 1, 1, 2'b00);
    run_write("wr_same", 32'h0000_2004, 32'hA5A5_A5A5, 4'b0001, 0, 0, 2, 2'b10);
    run_write("wr_aw_first", 32'h0000_3008, 32'h0BAD_F00D, 4'b0110, 0, 3, 0, 2'b01);
    run_read("rd_decerr", 32'h0000_400C, 0, 0, 32'hFFFF_0000, 2'b11);
    run_read("rd_ar_timeout", 32'h0000_5000, 1000, 0, 32'h1234_5678, 2'b00);
    run_write("wr_b_timeout", 32'h0000_6000, 32'h5555_AAAA, 4'hF, 0, 0, 1000, 2'b00);
    run_read("rd_r_late", 32'h0000_7000, 0, TO - 2, 32'h0F0F_0F0F, 2'b00);

    // Reset while waiting in WRESP: transaction dropped without a response.
    aw_dly = 0; w_dly = 0; b_dly = 1000;
    issue(1'b1, 32'h0000_0044, 32'h1234_5678, 4'hF);
    @(negedge m_axi_aclk);
    chk("rst_wresp bready", 32'(m_axi_bready), 32'd1);
    m_axi_aresetn = 1'b0;
    @(posedge m_axi_aclk);
    #1;
    chk_all_zero("rst_wresp");
    @(negedge m_axi_aclk);
    m_axi_aresetn = 1'b1;
    b_dly = 0;
    @(negedge m_axi_aclk);
    chk("rst_wresp release cmd_ready", 32'(cmd_ready), 32'd1);

    // Back-to-back: cmd_valid held across two commands.
    begin
      rsp_t ea, eb;
      int n = 0;
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
      s_rdata = 32'h5A5A_0001; s_rresp = 2'b00; s_bresp = 2'b00;
      ea.rdata = 32'h5A5A_0001; ea.resp = 2'b00; ea.to = 1'b0;
      eb.rdata = 32'd0;         eb.resp = 2'b00; eb.to = 1'b0;
      sb.push_back(ea);
      sb.push_back(eb);
      @(negedge m_axi_aclk);
      cmd_wr = 1'b0; cmd_addr = 32'h0000_0100; cmd_wdata = 32'd0; cmd_wstrb = 4'h0;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 40) begin @(negedge m_axi_aclk); n++; end
      chk("b2b first accept", 32'(cmd_ready), 32'd1);
      @(negedge m_axi_aclk);
      cmd_wr = 1'b1; cmd_addr = 32'h0000_0200; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'b0011;
      for (int c = 0; c <= 3; c++) begin
        chk($sformatf("b2b cmd_ready c%0d", c), 32'(cmd_ready), 32'(c == 3));
        chk($sformatf("b2b rsp_valid c%0d", c), 32'(rsp_valid), 32'(c == 2));
        if (c == 0) chk("b2b araddr held", m_axi_araddr, 32'h0000_0100);
        if (c < 3) @(negedge m_axi_aclk);
      end
      @(negedge m_axi_aclk);
      cmd_valid = 1'b0;
      chk("b2b second awvalid", 32'(m_axi_awvalid), 32'd1);
      chk("b2b second awaddr", m_axi_awaddr, 32'h0000_0200);
      chk("b2b second wdata", m_axi_wdata, 32'hDEAD_BEEF);
      chk("b2b second wstrb", 32'(m_axi_wstrb), 32'h3);
      repeat (3) @(negedge m_axi_aclk);
      chk("b2b end cmd_ready", 32'(cmd_ready), 32'd1);
    end

    repeat (3) @(negedge m_axi_aclk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
